vga_ctrl_param: RTL and testbench
=================================

Name: vga_ctrl_param

Overview:
Parametrised successor to the fixed 640x480 VGA controller. Generates VGA timing from parameters and drives framebuffer read addresses, with optional 2x/4x pixel replication. Compensates a configurable framebuffer read latency so colour, sync and blank stay aligned at the DAC. Sits between the core's framebuffer read port and the board VGA pins, clocked by the pixel clock.

Parameters:
H_ACTIVE, 640, visible pixels per line (must be divisible by 4)
H_FP, 16, horizontal front porch, in pixels
H_SYNC, 96, horizontal sync width, in pixels
H_BP, 48, horizontal back porch, in pixels
V_ACTIVE, 480, visible lines (must be divisible by 4)
V_FP, 10, vertical front porch, in lines
V_SYNC, 2, vertical sync width, in lines
V_BP, 33, vertical back porch, in lines
COLOR_BITS, 8, width of input colour channels
OUT_BITS, 8, width of DAC colour outputs
READ_LATENCY, 1, cycles from oAddress to valid iRed/iGreen/iBlue (1..4)
ADDR_BITS, 19, framebuffer address width
HS_POL, 0, active level of oVGA_HS
VS_POL, 0, active level of oVGA_VS

Ports:
iCLK  input  1  pixel clock
iRST_N  input  1  asynchronous reset, active low
iScale  input  2  replication mode: 0=1x, 1=2x, 2=4x, 3 treated as 4x
iRed  input  COLOR_BITS  red channel from framebuffer
iGreen  input  COLOR_BITS  green channel from framebuffer
iBlue  input  COLOR_BITS  blue channel from framebuffer
oAddress  output  ADDR_BITS  framebuffer read address
oRequest  output  1  high when oAddress is a valid visible-pixel read
oCurrent_X  output  16  visible column of the current request
oCurrent_Y  output  16  visible row of the current request
oFrame_start  output  1  one-cycle pulse at h=0, v=0
oLine_start  output  1  one-cycle pulse at h=0 of each line
oVGA_R, oVGA_G, oVGA_B  output  OUT_BITS  DAC colour outputs
oVGA_HS  output  1  horizontal sync
oVGA_VS  output  1  vertical sync
oVGA_BLANK  output  1  blank, active low (high in visible region)
oVGA_SYNC  output  1  composite sync, held 0
oVGA_CLOCK  output  1  ~iCLK

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way.
- Order in each dimension: active, then front porch, then sync, then back porch.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments on each h wrap and wraps at V_TOTAL-1.
- Reset (asynchronous, iRST_N=0): all counters and the pipeline clear. Outputs go to: oAddress=0, oRequest=0, X=Y=0, pulses=0, colours=0, oVGA_BLANK=0, HS=~HS_POL, VS=~VS_POL.
- Counting starts on the first iCLK edge after reset deasserts.
- Stage 0 (registered from the counters):
  - oRequest = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - oCurrent_X = h_cnt and oCurrent_Y = v_cnt while oRequest=1; otherwise they hold.
  - oFrame_start and oLine_start are also registered in stage 0.
- Scale mode s (0, 1 or 2): latched only at h=0, v=0. A mid-frame change takes effect on the next frame.
- Address generation is incremental, with no multiplier:
  - line_base resets to 0 at frame start.
  - At the start of each visible line, the address counter loads line_base.
  - The address counter increments after every 2^s visible pixels.
  - line_base advances by H_ACTIVE>>s after every 2^s visible lines.
  - oAddress is held when oRequest=0.
- Latency alignment:
  - Colour is sampled READ_LATENCY cycles after the oRequest/oAddress cycle.
  - HS, VS and blank pass through a READ_LATENCY-deep shift register.
  - All VGA outputs are registered together, so the DAC sees pixel (x,y) READ_LATENCY+1 cycles after its request.
- Width conversion:
  - OUT_BITS>COLOR_BITS: left-align the input and fill the LSBs by repeating the input MSBs.
  - OUT_BITS<COLOR_BITS: truncate the LSBs.
  - Example: COLOR_BITS=1, OUT_BITS=8 maps 1 to 8'hFF.
- When the delayed blank is inactive (outside the visible region), colours are forced to 0.
- Mid-frame reset: immediate asynchronous return to reset values. The frame restarts at h=0, v=0 with the scale re-latched.

Test Plan:
- Small timing (H 8/2/2/2, V 4/1/1/1), reset held -> every output at its reset value. Release -> oFrame_start pulses once, one cycle after the first edge.
- Free run, HS_POL=VS_POL=0 -> HS low 2 of every 14 cycles; VS low 14 of every 98 cycles; oRequest high 8 cycles per line on lines 0-3 only; oVGA_BLANK high 32 cycles per frame.
- iScale=0 -> addresses 0..7 on line 0, 8..15 on line 1, up to 31 on line 3; X and Y track the counters.
- iScale=1, set mid-frame -> the current frame is unchanged. Next frame: line 0 reads 0,0,1,1,2,2,3,3; line 1 repeats line 0; line 2 reads 4,4,5,5,6,6,7,7.
- READ_LATENCY=2, COLOR_BITS=1, OUT_BITS=8, memory model returns addr[0] -> oVGA_R alternates 00/FF. BLANK rises exactly 3 cycles after oRequest rises, and HS moves with the same 3-cycle offset.
- iRST_N pulsed low at h=5, v=2 -> outputs reset asynchronously, before the next edge. After release: counters restart at 0 and the first oAddress=0.

Source files
------------

// File: rtl/vga_ctrl_param.sv
// vga_ctrl_param: parametrised VGA timing generator with framebuffer address generation,
// 1x/2x/4x pixel replication and read-latency compensation of colour, sync and blank.
`default_nettype none

module vga_ctrl_param #(
    parameter int   H_ACTIVE     = 640,
    parameter int   H_FP         = 16,
    parameter int   H_SYNC       = 96,
    parameter int   H_BP         = 48,
    parameter int   V_ACTIVE     = 480,
    parameter int   V_FP         = 10,
    parameter int   V_SYNC       = 2,
    parameter int   V_BP         = 33,
    parameter int   COLOR_BITS   = 8,
    parameter int   OUT_BITS     = 8,
    parameter int   READ_LATENCY = 1,
    parameter int   ADDR_BITS    = 19,
    parameter logic HS_POL       = 1'b0,
    parameter logic VS_POL       = 1'b0
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic [1:0]            iScale,
    input  logic [COLOR_BITS-1:0] iRed,
    input  logic [COLOR_BITS-1:0] iGreen,
    input  logic [COLOR_BITS-1:0] iBlue,
    output logic [ADDR_BITS-1:0]  oAddress,
    output logic                  oRequest,
    output logic [15:0]           oCurrent_X,
    output logic [15:0]           oCurrent_Y,
    output logic                  oFrame_start,
    output logic                  oLine_start,
    output logic [OUT_BITS-1:0]   oVGA_R,
    output logic [OUT_BITS-1:0]   oVGA_G,
    output logic [OUT_BITS-1:0]   oVGA_B,
    output logic                  oVGA_HS,
    output logic                  oVGA_VS,
    output logic                  oVGA_BLANK,
    output logic                  oVGA_SYNC,
    output logic                  oVGA_CLOCK
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_VIS_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_SS       = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE       = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS       = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE       = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0]           h_cnt;
    logic [VW-1:0]           v_cnt;
    logic [1:0]              scale;
    logic [1:0]              scale_in;
    logic [1:0]              rep_mask;
    logic [1:0]              pix_sub;
    logic [1:0]              pix_sub_next;
    logic [1:0]              line_sub;
    logic [ADDR_BITS-1:0]    line_base;
    logic [ADDR_BITS-1:0]    line_step;
    logic [ADDR_BITS-1:0]    addr_next;
    logic                    visible;
    logic                    frame_edge;
    logic                    line_end;
    logic                    hs_act;
    logic                    vs_act;
    logic                    s0_hs;
    logic                    s0_vs;
    logic [READ_LATENCY-1:0] hs_d;
    logic [READ_LATENCY-1:0] vs_d;
    logic [READ_LATENCY-1:0] bl_d;

    // Left-align the colour and refill the LSBs by cycling through its MSBs.
    function automatic logic [OUT_BITS-1:0] widen(input logic [COLOR_BITS-1:0] c);
        logic [OUT_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < OUT_BITS; i++) begin
            r[OUT_BITS-1-i] = c[COLOR_BITS-1-(i % COLOR_BITS)];
        end
        return r;
    endfunction

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        visible    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        frame_edge = (h_cnt == '0) && (v_cnt == '0);
        line_end   = (h_cnt == H_VIS_LAST) && (v_cnt < V_VIS);
        hs_act     = (h_cnt >= H_SS) && (h_cnt < H_SE);
        vs_act     = (v_cnt >= V_SS) && (v_cnt < V_SE);
        scale_in   = (iScale == 2'd0) ? 2'd0 : (iScale == 2'd1) ? 2'd1 : 2'd2;
        case (scale)
            2'd0:    rep_mask = 2'd0;
            2'd1:    rep_mask = 2'd1;
            default: rep_mask = 2'd3;
        endcase
        line_step = ADDR_BITS'(H_ACTIVE >> scale);
    end

    // Incremental address: reload the line base at h=0, step once per replicated pixel.
    always_comb begin
        addr_next    = oAddress;
        pix_sub_next = pix_sub;
        if (visible) begin
            if (h_cnt == '0) begin
                addr_next    = frame_edge ? '0 : line_base;
                pix_sub_next = '0;
            end else if (pix_sub == rep_mask) begin
                addr_next    = oAddress + 1'b1;
                pix_sub_next = '0;
            end else begin
                pix_sub_next = pix_sub + 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            scale     <= '0;
            line_base <= '0;
            line_sub  <= '0;
        end else if (frame_edge) begin
            scale     <= scale_in;
            line_base <= '0;
            line_sub  <= '0;
        end else if (line_end) begin
            if (line_sub == rep_mask) begin
                line_base <= line_base + line_step;
                line_sub  <= '0;
            end else begin
                line_sub  <= line_sub + 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oAddress     <= '0;
            oRequest     <= 1'b0;
            oCurrent_X   <= '0;
            oCurrent_Y   <= '0;
            oFrame_start <= 1'b0;
            oLine_start  <= 1'b0;
            pix_sub      <= '0;
            s0_hs        <= 1'b0;
            s0_vs        <= 1'b0;
        end else begin
            oAddress     <= addr_next;
            oRequest     <= visible;
            oFrame_start <= frame_edge;
            oLine_start  <= (h_cnt == '0);
            pix_sub      <= pix_sub_next;
            s0_hs        <= hs_act;
            s0_vs        <= vs_act;
            if (visible) begin
                oCurrent_X <= 16'(h_cnt);
                oCurrent_Y <= 16'(v_cnt);
            end
        end
    end

    // Timing bits wait READ_LATENCY cycles so they meet the returning colour.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hs_d <= '0;
            vs_d <= '0;
            bl_d <= '0;
        end else begin
            hs_d[0] <= s0_hs;
            vs_d[0] <= s0_vs;
            bl_d[0] <= oRequest;
            for (int i = 1; i < READ_LATENCY; i++) begin
                hs_d[i] <= hs_d[i-1];
                vs_d[i] <= vs_d[i-1];
                bl_d[i] <= bl_d[i-1];
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oVGA_R     <= '0;
            oVGA_G     <= '0;
            oVGA_B     <= '0;
            oVGA_HS    <= ~HS_POL;
            oVGA_VS    <= ~VS_POL;
            oVGA_BLANK <= 1'b0;
        end else begin
            oVGA_R     <= bl_d[READ_LATENCY-1] ? widen(iRed)   : '0;
            oVGA_G     <= bl_d[READ_LATENCY-1] ? widen(iGreen) : '0;
            oVGA_B     <= bl_d[READ_LATENCY-1] ? widen(iBlue)  : '0;
            oVGA_HS    <= hs_d[READ_LATENCY-1] ? HS_POL : ~HS_POL;
            oVGA_VS    <= vs_d[READ_LATENCY-1] ? VS_POL : ~VS_POL;
            oVGA_BLANK <= bl_d[READ_LATENCY-1];
        end
    end

    assign oVGA_SYNC  = 1'b0;
    assign oVGA_CLOCK = ~iCLK;

endmodule

`default_nettype wire

// File: tb/tb_vga_ctrl_param.sv
// Bench for vga_ctrl_param: small timing, two instances (latency 1 / 8-bit colour and
// latency 2 / 1-bit colour) checked against a counter model and colour scoreboards.
`default_nettype none

module tb_vga_ctrl_param;

    localparam int HA = 8;
    localparam int VA = 4;
    localparam int HT = 14;
    localparam int VT = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] scale = 2'd0;

    logic [7:0]  a_addr, a_r, a_g, a_b, a_ir, a_ig, a_ib;
    logic [15:0] a_x, a_y;
    logic        a_req, a_fs, a_ls, a_hs, a_vs, a_blank, a_sync, a_vclk;

    logic [7:0]  b_addr, b_r, b_g, b_b;
    logic [15:0] b_x, b_y;
    logic        b_req, b_fs, b_ls, b_hs, b_vs, b_blank, b_sync, b_vclk;
    logic        b_q1, b_q2;
    logic [0:0]  b_ir, b_ig, b_ib;

    vga_ctrl_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .COLOR_BITS(8), .OUT_BITS(8), .READ_LATENCY(1), .ADDR_BITS(8),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_a (
        .iCLK(clk), .iRST_N(rst_n), .iScale(scale),
        .iRed(a_ir), .iGreen(a_ig), .iBlue(a_ib),
        .oAddress(a_addr), .oRequest(a_req), .oCurrent_X(a_x), .oCurrent_Y(a_y),
        .oFrame_start(a_fs), .oLine_start(a_ls),
        .oVGA_R(a_r), .oVGA_G(a_g), .oVGA_B(a_b),
        .oVGA_HS(a_hs), .oVGA_VS(a_vs), .oVGA_BLANK(a_blank),
        .oVGA_SYNC(a_sync), .oVGA_CLOCK(a_vclk)
    );

    vga_ctrl_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .COLOR_BITS(1), .OUT_BITS(8), .READ_LATENCY(2), .ADDR_BITS(8),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_b (
        .iCLK(clk), .iRST_N(rst_n), .iScale(2'd0),
        .iRed(b_ir), .iGreen(b_ig), .iBlue(b_ib),
        .oAddress(b_addr), .oRequest(b_req), .oCurrent_X(b_x), .oCurrent_Y(b_y),
        .oFrame_start(b_fs), .oLine_start(b_ls),
        .oVGA_R(b_r), .oVGA_G(b_g), .oVGA_B(b_b),
        .oVGA_HS(b_hs), .oVGA_VS(b_vs), .oVGA_BLANK(b_blank),
        .oVGA_SYNC(b_sync), .oVGA_CLOCK(b_vclk)
    );

    always #5 clk = ~clk;

    // Framebuffer models: A has one cycle of read latency, B has two and returns addr[0].
    always @(posedge clk) begin
        a_ir <= a_addr ^ 8'h5A;
        a_ig <= a_addr + 8'd3;
        a_ib <= ~a_addr;
        b_q1 <= b_addr[0];
        b_q2 <= b_q1;
    end
    assign b_ir = b_q2;
    assign b_ig = b_q2;
    assign b_ib = ~b_q2;

    int checks = 0;
    int errors = 0;
    int th, tv, ms, lx, ly;
    bit req_h[4];
    bit hs_h[4];
    bit vs_h[4];
    logic [23:0] qa[$];
    logic [15:0] qb[$];
    bit   stats_en = 1'b0;
    int   hs_low, vs_low, req_cnt, blank_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        th = 0; tv = 0; lx = 0; ly = 0;
        for (int i = 0; i < 4; i++) begin
            req_h[i] = 1'b0; hs_h[i] = 1'b0; vs_h[i] = 1'b0;
        end
        qa.delete();
        qb.delete();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_addr"},  a_addr, 0);
        chk({tag, "_req"},   a_req, 0);
        chk({tag, "_xy"},    {a_x, a_y}, 0);
        chk({tag, "_pulse"}, {a_fs, a_ls}, 0);
        chk({tag, "_rgb"},   {a_r, a_g, a_b}, 0);
        chk({tag, "_blank"}, a_blank, 0);
        chk({tag, "_hsvs"},  {a_hs, a_vs}, 2'b11);
        chk({tag, "_b_out"}, {b_req, b_blank, b_r, b_hs, b_vs}, {2'b00, 8'h00, 2'b11});
    endtask

    task automatic step();
        int ea, eb;
        logic [7:0] er;
        logic [23:0] ea_rgb;
        logic [15:0] eb_rb;
        bit vis, hsa, vsa, fe;
        vis = (th < HA) && (tv < VA);
        hsa = (th >= 10) && (th < 12);
        vsa = (tv == 5);
        fe  = (th == 0) && (tv == 0);
        if (fe) ms = (scale == 2'd0) ? 0 : (scale == 2'd1) ? 1 : 2;
        @(posedge clk);
        #1;
        chk("req", a_req, vis);
        chk("b_req", b_req, vis);
        chk("frame_start", a_fs, fe);
        chk("line_start", a_ls, th == 0);
        if (vis) begin
            ea = (tv >> ms) * (HA >> ms) + (th >> ms);
            eb = tv * HA + th;
            lx = th; ly = tv;
            chk("addr", a_addr, ea);
            chk("b_addr", b_addr, eb);
            ea_rgb = {8'(ea) ^ 8'h5A, 8'(ea + 3), ~8'(ea)};
            er = (eb % 2 == 1) ? 8'hFF : 8'h00;
            eb_rb = {er, ~er};
            qa.push_back(ea_rgb);
            qb.push_back(eb_rb);
        end
        chk("cur_xy", {a_x, a_y}, {16'(lx), 16'(ly)});
        for (int i = 3; i > 0; i--) begin
            req_h[i] = req_h[i-1]; hs_h[i] = hs_h[i-1]; vs_h[i] = vs_h[i-1];
        end
        req_h[0] = vis; hs_h[0] = hsa; vs_h[0] = vsa;

        chk("a_blank", a_blank, req_h[2]);
        chk("a_hs", a_hs, !hs_h[2]);
        chk("a_vs", a_vs, !vs_h[2]);
        if (a_blank === 1'b1) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $error("FAIL a_rgb_underflow: observed pixel expected none");
            end else begin
                chk("a_rgb", {a_r, a_g, a_b}, qa.pop_front());
            end
        end else begin
            chk("a_rgb_blanked", {a_r, a_g, a_b}, 0);
        end

        chk("b_blank", b_blank, req_h[3]);
        chk("b_hs", b_hs, !hs_h[3]);
        if (b_blank === 1'b1) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $error("FAIL b_rgb_underflow: observed pixel expected none");
            end else begin
                chk("b_rb", {b_r, b_b}, qb.pop_front());
            end
        end else begin
            chk("b_rgb_blanked", {b_r, b_g, b_b}, 0);
        end

        if (stats_en) begin
            hs_low    += (a_hs == 1'b0) ? 1 : 0;
            vs_low    += (a_vs == 1'b0) ? 1 : 0;
            req_cnt   += (a_req == 1'b1) ? 1 : 0;
            blank_cnt += (a_blank == 1'b1) ? 1 : 0;
        end

        if (th == HT - 1) begin
            th = 0;
            tv = (tv == VT - 1) ? 0 : tv + 1;
        end else begin
            th++;
        end
    endtask

    initial begin
        model_reset();
        ms = 0;
        hs_low = 0; vs_low = 0; req_cnt = 0; blank_cnt = 0;

        // Reset held across several edges.
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        chk("sync_clock", {a_sync, a_vclk, b_sync}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 0 at 1x; scale request to 2x arrives mid-frame.
        for (int i = 0; i < HT * VT; i++) begin
            if (i == 40) scale = 2'd1;
            step();
        end

        // Frame 1 at 2x, gathering per-frame timing counts; 4x (code 3) requested mid-frame.
        stats_en = 1'b1;
        for (int i = 0; i < HT * VT; i++) begin
            if (i == 50) scale = 2'd3;
            step();
        end
        stats_en = 1'b0;
        chk("hs_low_per_frame", hs_low, 14);
        chk("vs_low_per_frame", vs_low, 14);
        chk("req_per_frame", req_cnt, 32);
        chk("blank_per_frame", blank_cnt, 32);

        // Frame 2 at 4x, then run into frame 3 up to h=5, v=2.
        for (int i = 0; i < HT * VT; i++) step();
        for (int i = 0; i < 2 * HT + 5; i++) step();
        chk("model_pos", {th[7:0], tv[7:0]}, {8'd5, 8'd2});

        // Asynchronous mid-frame reset: outputs must clear before the next edge.
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(posedge clk);
        #1;
        check_reset_values("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < HT * VT; i++) step();
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
